// File: rtl/clock_pkg.sv
// Shared types for the multi-mode clock's time-setting control.
// Holds the state enum, field encodings and the per-field pulse bit positions.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EDIT_H = 3'd2,
        ST_EDIT_M = 3'd3,
        ST_EDIT_S = 3'd4,
        ST_EXIT   = 3'd5
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_SEC  = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_HOUR = 2'd3;

    localparam int HOUR_BIT = 2;
    localparam int MIN_BIT  = 1;
    localparam int SEC_BIT  = 0;

    function automatic logic is_edit(input state_e s);
        return (s == ST_EDIT_H) || (s == ST_EDIT_M) || (s == ST_EDIT_S);
    endfunction

    function automatic logic [1:0] field_code(input state_e s);
        case (s)
            ST_EDIT_H: return FIELD_HOUR;
            ST_EDIT_M: return FIELD_MIN;
            ST_EDIT_S: return FIELD_SEC;
            default:   return FIELD_NONE;
        endcase
    endfunction

    function automatic logic [2:0] field_onehot(input state_e s);
        logic [2:0] oh;
        oh = 3'b000;
        case (s)
            ST_EDIT_H: oh[HOUR_BIT] = 1'b1;
            ST_EDIT_M: oh[MIN_BIT]  = 1'b1;
            ST_EDIT_S: oh[SEC_BIT]  = 1'b1;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Edited field order is hour -> minute -> second -> hour.
    function automatic state_e next_field(input state_e s);
        case (s)
            ST_EDIT_H: return ST_EDIT_M;
            ST_EDIT_M: return ST_EDIT_S;
            default:   return ST_EDIT_H;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_key_repeat.sv
// Edge detect plus auto-repeat for one debounced adjust button.
// A masked rise is swallowed and leaves the key unarmed until its next rise.
module key_repeat #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic active,
    input  logic mask,
    output logic fire
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    logic          prev_q, prev_d;
    logic          armed_q, armed_d;
    logic          repeating_q, repeating_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;

    always_comb begin
        rise        = level & ~prev_q;
        prev_d      = level;
        armed_d     = 1'b0;
        repeating_d = 1'b0;
        cnt_d       = '0;
        fire        = 1'b0;
        if (active) begin
            if (rise) begin
                armed_d = ~mask;
                fire    = ~mask;
            end else if (level && armed_q) begin
                armed_d = 1'b1;
                if ((!repeating_q && cnt_q == DELAY_LAST) ||
                    (repeating_q && cnt_q == RATE_LAST)) begin
                    fire        = ~mask;
                    repeating_d = 1'b1;
                end else begin
                    repeating_d = repeating_q;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            repeating_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            repeating_q <= repeating_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: turns debounced buttons into load/edit/leave strobes,
// per-field adjust pulses with auto-repeat, inactivity timeout and display blink.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int TIMEOUT      = 5000,
    parameter int BLINK_HALF   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       modify,
    output logic       set_sign,
    output logic       en,
    output logic       leave,
    output logic [2:0] signal_increase,
    output logic [2:0] signal_decrease,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic       commit,
    output logic       editing
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_e        state_q, state_d;
    logic          mode_prev_q, next_prev_q;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    logic       set_sign_q, set_sign_d;
    logic       en_q, en_d;
    logic       leave_q, leave_d;
    logic [2:0] inc_q, inc_d;
    logic [2:0] dec_q, dec_d;
    logic [1:0] field_sel_q, field_sel_d;
    logic       blink_q, blink_d;
    logic       commit_q, commit_d;
    logic       editing_q, editing_d;

    logic mode_rise, next_rise, in_edit, any_held, timeout_hit;
    logic key_active, key_mask, up_fire, down_fire;

    assign mode_rise   = btn_mode & ~mode_prev_q;
    assign next_rise   = btn_next & ~next_prev_q;
    assign in_edit     = is_edit(state_q);
    assign any_held    = btn_mode | btn_next | btn_up | btn_down;
    assign timeout_hit = in_edit && (to_cnt_q == TO_LAST);
    // Up and down together silence both keys; higher-priority events swallow adjust edges.
    assign key_active  = in_edit & ~(btn_up & btn_down);
    assign key_mask    = mode_rise | timeout_hit | next_rise;

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk(clk), .rst(rst), .level(btn_up), .active(key_active), .mask(key_mask), .fire(up_fire)
    );

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
        .clk(clk), .rst(rst), .level(btn_down), .active(key_active), .mask(key_mask), .fire(down_fire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (mode_rise) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_EDIT_H;
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (mode_rise || timeout_hit) state_d = ST_EXIT;
                else if (next_rise)           state_d = next_field(state_q);
            end
            ST_EXIT:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        to_cnt_d = '0;
        if (in_edit && is_edit(state_d) && !any_held) to_cnt_d = to_cnt_q + 1'b1;

        // Outputs are decoded from the next state so they land in flops alongside it.
        set_sign_d  = (state_d == ST_LOAD);
        en_d        = is_edit(state_d);
        leave_d     = (state_d == ST_EXIT);
        commit_d    = (state_d == ST_EXIT) & modify;
        editing_d   = (state_d != ST_IDLE);
        field_sel_d = field_code(state_d);
        inc_d       = up_fire   ? field_onehot(state_q) : 3'b000;
        dec_d       = down_fire ? field_onehot(state_q) : 3'b000;

        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (is_edit(state_d)) begin
            if ((state_d == ST_EDIT_H && state_q != ST_EDIT_H) || up_fire || down_fire) begin
                blink_cnt_d = '0;
                blink_d     = 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_prev_q <= 1'b0;
            next_prev_q <= 1'b0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            set_sign_q  <= 1'b0;
            en_q        <= 1'b0;
            leave_q     <= 1'b0;
            inc_q       <= 3'b000;
            dec_q       <= 3'b000;
            field_sel_q <= FIELD_NONE;
            blink_q     <= 1'b0;
            commit_q    <= 1'b0;
            editing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            next_prev_q <= btn_next;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            set_sign_q  <= set_sign_d;
            en_q        <= en_d;
            leave_q     <= leave_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            field_sel_q <= field_sel_d;
            blink_q     <= blink_d;
            commit_q    <= commit_d;
            editing_q   <= editing_d;
        end
    end

    assign set_sign        = set_sign_q;
    assign en              = en_q;
    assign leave           = leave_q;
    assign signal_increase = inc_q;
    assign signal_decrease = dec_q;
    assign field_sel       = field_sel_q;
    assign blink           = blink_q;
    assign commit          = commit_q;
    assign editing         = editing_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a fixed vector table, hand-built corner-case sequences and
// a long random run, every cycle compared against a behavioural model of the rules.
module tb_time_set_ctrl;

    localparam int RD = 4;
    localparam int RR = 2;
    localparam int TO = 20;
    localparam int BH = 3;

    logic       clk, rst, btn_mode, btn_next, btn_up, btn_down, modify;
    logic       set_sign, en, leave, blink, commit, editing;
    logic [2:0] signal_increase, signal_decrease;
    logic [1:0] field_sel;

    typedef struct packed {
        logic       set_sign;
        logic       en;
        logic       leave;
        logic [2:0] incr;
        logic [2:0] decr;
        logic [1:0] fs;
        logic       blink;
        logic       commit;
        logic       editing;
    } out_t;

    typedef struct {
        logic r, m, n, u, d, mod;
        out_t exp;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    out_t act;
    out_t m_exp;

    // Behavioural model: plain counts of cycles, not the RTL's counters.
    int         m_state;
    int         m_field;
    logic [3:0] m_prev;
    int         m_held[2];
    int         m_quiet;
    int         m_since;

    time_set_ctrl #(
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .modify(modify),
        .set_sign(set_sign), .en(en), .leave(leave),
        .signal_increase(signal_increase), .signal_decrease(signal_decrease),
        .field_sel(field_sel), .blink(blink), .commit(commit), .editing(editing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mkOut(input logic ss, e, lv, input logic [2:0] inc, dec,
                                   input logic [1:0] fs, input logic bl, cm, ed);
        out_t o;
        o = '{set_sign: ss, en: e, leave: lv, incr: inc, decr: dec, fs: fs,
              blink: bl, commit: cm, editing: ed};
        return o;
    endfunction

    // A held key pulses on its rise, after RD cycles, then every RR cycles.
    function automatic logic isRepeatPoint(input int n);
        return (n == 0) || (n == RD) || (n > RD && ((n - RD) % RR) == 0);
    endfunction

    function automatic logic nextLevel(input logic cur, input int pressPct);
        if (cur) return ($urandom_range(0, 99) >= 25);
        return ($urandom_range(0, 99) < pressPct);
    endfunction

    task automatic modelReset();
        m_state   = 0;
        m_field   = 0;
        m_prev    = 4'b0000;
        m_held[0] = -1;
        m_held[1] = -1;
        m_quiet   = 0;
        m_since   = 0;
        m_exp     = '0;
    endtask

    task automatic modelStep(input logic r, m, n, u, d, mod);
        logic [3:0] lv, rs;
        logic       pu, pd, tmo;
        int         oldf;
        lv    = {d, u, n, m};
        rs    = lv & ~m_prev;
        pu    = 1'b0;
        pd    = 1'b0;
        m_exp = '0;
        if (r) begin
            modelReset();
        end else begin
            m_prev = lv;
            case (m_state)
                0: begin
                    m_held[0] = -1;
                    m_held[1] = -1;
                    if (rs[0]) begin
                        m_state         = 1;
                        m_exp.set_sign  = 1'b1;
                        m_exp.editing   = 1'b1;
                    end
                end
                1: begin
                    m_state       = 2;
                    m_field       = 3;
                    m_quiet       = 0;
                    m_since       = 0;
                    m_held[0]     = -1;
                    m_held[1]     = -1;
                    m_exp.en      = 1'b1;
                    m_exp.editing = 1'b1;
                    m_exp.fs      = 2'd3;
                end
                2: begin
                    tmo = (m_quiet == TO - 1);
                    if (rs[0] || tmo) begin
                        m_state       = 3;
                        m_exp.leave   = 1'b1;
                        m_exp.commit  = mod;
                        m_exp.editing = 1'b1;
                        m_held[0]     = -1;
                        m_held[1]     = -1;
                    end else begin
                        oldf = m_field;
                        if (rs[1]) m_field = (m_field == 1) ? 3 : m_field - 1;
                        if (lv[2] && lv[3]) begin
                            m_held[0] = -1;
                            m_held[1] = -1;
                        end else begin
                            for (int k = 0; k < 2; k++) begin
                                if (rs[2+k])                       m_held[k] = rs[1] ? -1 : 0;
                                else if (lv[2+k] && m_held[k] >= 0) m_held[k] = m_held[k] + 1;
                                else                                m_held[k] = -1;
                            end
                            pu = !rs[1] && m_held[0] >= 0 && isRepeatPoint(m_held[0]);
                            pd = !rs[1] && m_held[1] >= 0 && isRepeatPoint(m_held[1]);
                        end
                        m_quiet = (lv != 4'b0000) ? 0 : m_quiet + 1;
                        if ((rs[1] && m_field == 3) || pu || pd) m_since = 0;
                        else                                     m_since = m_since + 1;
                        m_exp.en      = 1'b1;
                        m_exp.editing = 1'b1;
                        m_exp.fs      = 2'(m_field);
                        m_exp.incr    = pu ? 3'(32'd1 << (oldf - 1)) : 3'b000;
                        m_exp.decr    = pd ? 3'(32'd1 << (oldf - 1)) : 3'b000;
                        m_exp.blink   = ((m_since / BH) % 2) == 1;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        act = out_t'({set_sign, en, leave, signal_increase, signal_decrease,
                      field_sel, blink, commit, editing});
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got ss=%b en=%b lv=%b inc=%b dec=%b fs=%0d bl=%b cm=%b ed=%b, expected ss=%b en=%b lv=%b inc=%b dec=%b fs=%0d bl=%b cm=%b ed=%b",
                     name, $time, act.set_sign, act.en, act.leave, act.incr, act.decr, act.fs,
                     act.blink, act.commit, act.editing, exp.set_sign, exp.en, exp.leave,
                     exp.incr, exp.decr, exp.fs, exp.blink, exp.commit, exp.editing);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, model on the rising edge, compare just after.
    task automatic applyStimulus(input logic r, m, n, u, d, mod);
        @(negedge clk);
        rst      = r;
        btn_mode = m;
        btn_next = n;
        btn_up   = u;
        btn_down = d;
        modify   = mod;
        @(posedge clk);
        modelStep(r, m, n, u, d, mod);
        #1;
        checkOutput("model", m_exp);
    endtask

    task automatic enterEdit();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int   firstLeave;
        int   pulses;
        logic rm, rn, ru, rd;

        rst = 1'b1; btn_mode = 1'b0; btn_next = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; modify = 1'b0;
        modelReset();

        // r m n u d mod | ss en lv inc dec fs bl cm ed
        vq.push_back('{1,0,0,0,0,0, mkOut(0,0,0,3'b000,3'b000,2'd0,0,0,0)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,0,0,3'b000,3'b000,2'd0,0,0,0)});
        vq.push_back('{0,1,0,0,0,0, mkOut(1,0,0,3'b000,3'b000,2'd0,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,1,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd2,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd2,1,0,1)});
        vq.push_back('{0,0,1,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd1,1,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd1,1,0,1)});
        vq.push_back('{0,0,1,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,0,1,0,0, mkOut(0,1,0,3'b100,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,0,0,0,1,0, mkOut(0,1,0,3'b000,3'b100,2'd3,0,0,1)});
        vq.push_back('{0,0,0,0,0,0, mkOut(0,1,0,3'b000,3'b000,2'd3,0,0,1)});
        vq.push_back('{0,1,0,0,0,1, mkOut(0,0,1,3'b000,3'b000,2'd0,0,1,1)});
        vq.push_back('{0,0,0,0,0,1, mkOut(0,0,0,3'b000,3'b000,2'd0,0,0,0)});

        foreach (vq[i]) begin
            applyStimulus(vq[i].r, vq[i].m, vq[i].n, vq[i].u, vq[i].d, vq[i].mod);
            checkOutput($sformatf("table[%0d]", i), vq[i].exp);
        end

        // Held up in the minute field: output after tick t reflects clock cycle t+1 after the rise.
        enterEdit();
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 10; t++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkValue($sformatf("repeat_inc[%0d]", t + 1), int'(act.incr),
                       (t == 0 || t == 4 || t == 6 || t == 8) ? 2 : 0);
            checkValue($sformatf("repeat_dec[%0d]", t + 1), int'(act.decr), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Seconds field, up and down together: no pulses at all.
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkValue("field_sec", int'(act.fs), 1);
        pulses = 0;
        for (int t = 0; t < 9; t++) begin
            applyStimulus(0, 0, 0, (t < 8), (t < 8), 0);
            if (act.incr != 3'b000 || act.decr != 3'b000) pulses++;
        end
        checkValue("both_held_pulses", pulses, 0);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkValue("exit_nomod_leave", int'(act.leave), 1);
        checkValue("exit_nomod_commit", int'(act.commit), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkValue("exit_nomod_idle", int'(act.editing), 0);

        // Inactivity timeout, then a timeout restarted by a press on the 15th quiet cycle.
        enterEdit();
        firstLeave = 0;
        for (int j = 1; j <= 25; j++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (act.leave && firstLeave == 0) firstLeave = j;
        end
        checkValue("timeout_cycle", firstLeave, 20);

        enterEdit();
        firstLeave = 0;
        for (int j = 1; j <= 45; j++) begin
            applyStimulus(0, 0, (j == 15), 0, 0, 0);
            if (act.leave && firstLeave == 0) firstLeave = j;
        end
        checkValue("timeout_restart_cycle", firstLeave, 35);

        // Mode and up rising together: exit wins, no increase pulse.
        enterEdit();
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkValue("mode_up_leave", int'(act.leave), 1);
        checkValue("mode_up_inc", int'(act.incr), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkValue("mode_up_inc_after", int'(act.incr), 0);

        // Reset in the middle of an auto-repeat: everything drops, no leave.
        enterEdit();
        for (int t = 0; t < 6; t++) applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("reset_mid_repeat", '0);
        for (int t = 0; t < 5; t++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput("after_reset", '0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Random run against the model.
        rm = 1'b0; rn = 1'b0; ru = 1'b0; rd = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rm = nextLevel(rm, 3);
            rn = nextLevel(rn, 6);
            ru = nextLevel(ru, 8);
            rd = nextLevel(rd, 5);
            applyStimulus(($urandom_range(0, 199) == 0), rm, rn, ru, rd,
                          logic'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
